if_prefetch_queue: RTL and testbench
====================================

IF_PREFETCH_QUEUE -- requirements
Module: if_prefetch_queue

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter: DEPTH, 4, FIFO entries (power of two, 2..16).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 mem_req  output  1  fetch request to instruction memory.
REQ-006 mem_addr  output  32  word-aligned fetch address; stable while mem_req high.
REQ-007 mem_rdata  input  32  instruction word; sampled only when mem_valid high.
REQ-008 mem_valid  input  1  response strobe; legal only while mem_req high, including the first cycle of a request.
REQ-009 inst_valid  output  1  FIFO head holds a valid instruction.
REQ-010 inst_out  output  32  FIFO head instruction, feeds IF/ID register InstIn.
REQ-011 pc_out  output  32  address of inst_out.
REQ-012 pause  input  1  consumer stall; head is not popped while high.
REQ-013 redirect  input  1  flush and restart fetch (branch/jump resolved in ID).
REQ-014 redirect_pc  input  32  new fetch address; bits [1:0] ignored, treated as 2'b00.
REQ-015 level  output  log2(DEPTH)+1  current FIFO occupancy.

Function
REQ-016 States SHALL be IDLE (no request), WAIT (request outstanding), DROP (request outstanding, response to be discarded); at most one request outstanding.
REQ-017 mem_req SHALL be 1 exactly in WAIT and DROP; mem_addr SHALL equal req_addr, a register loaded from fetch_pc on every entry to WAIT.
REQ-018 IDLE->WAIT when redirect=0 and level<DEPTH; otherwise stay IDLE.
REQ-019 In WAIT with mem_valid=1, redirect=0: push {req_addr, mem_rdata}, fetch_pc+=4 (mod 2^32); next state WAIT if post-update level<DEPTH, else IDLE.
REQ-020 In WAIT with mem_valid=0: stay WAIT, no change.
REQ-021 Pop SHALL occur when inst_valid=1 and pause=0 and redirect=0; push and pop in the same cycle leave level unchanged.
REQ-022 inst_valid SHALL be (level!=0); inst_out/pc_out SHALL be the head entry, registered (no mem_rdata bypass): mem_valid sampled at edge k gives inst_valid=1 after edge k at the earliest.
REQ-023 A push SHALL never occur at level=DEPTH; REQ-018/019 guarantee this and no overflow path exists.
REQ-024 Pop at level=0 SHALL be impossible (inst_valid=0); pointers wrap modulo DEPTH.
REQ-025 redirect=1 SHALL have priority over push and pop: level->0, pointers->0, fetch_pc<-{redirect_pc[31:2],2'b00}, effective next edge.
REQ-026 redirect in IDLE: stay IDLE; in WAIT with mem_valid=0: go DROP (mem_req, mem_addr held); in WAIT with mem_valid=1: response discarded, go IDLE; in DROP: fetch_pc updated, stay DROP unless mem_valid=1, then go IDLE.
REQ-027 In DROP with mem_valid=1 and redirect=0: discard mem_rdata, fetch_pc unchanged, go IDLE.
REQ-028 Continuous redirect SHALL hold level=0 and issue no new request.

Reset
REQ-029 rst=1 at an edge SHALL force state IDLE, fetch_pc=RESET_PC, req_addr=RESET_PC, level=0, pointers=0, all storage entries=0, overriding redirect and mem_valid.
REQ-030 Outputs during/after reset: mem_req=0, mem_addr=RESET_PC, inst_valid=0, inst_out=0, pc_out=0, level=0.
REQ-031 Reset while in WAIT/DROP SHALL abandon the request; the memory model is reset concurrently, so no stale mem_valid follows.

Verification
REQ-032 Zero-wait memory (mem_valid=mem_req), pause=0: after reset, pc_out sequence 0x0,0x4,0x8,... with at most one bubble after startup; level<=2.
REQ-033 pause=1 held, zero-wait memory: level rises to 4, mem_req drops to 0; release pause -> pc_out 0x0..0xC popped in order, fetching resumes at 0x10.
REQ-034 Memory latency 3 cycles, redirect to 0x100 in second WAIT cycle of fetch at 0x8: state DROP, mem_addr stays 0x8 until mem_valid, that word never appears; next request mem_addr=0x100, first pc_out after flush =0x100.
REQ-035 redirect with level=3, same cycle as mem_valid and pause=0: level=0 next cycle, no pop counted, pushed word discarded, inst_valid=0.
REQ-036 redirect_pc=0x0000_0207: fetch resumes at 0x204; fetch_pc at 0xFFFF_FFFC wraps to 0x0000_0000.
REQ-037 rst asserted in WAIT with level=2 -> next cycle mem_req=0, mem_addr=RESET_PC, inst_valid=0, level=0.

Source files
------------

// File: rtl/if_prefetch_queue_if.sv
// ----------------------------------------------------------------------------
// if_prefetch_queue_if
// Groups the signals between the instruction prefetch queue, the instruction
// memory and the decode stage.
//   master : the prefetch queue (drives the memory request and the FIFO head)
//   slave  : the environment (memory response, decode-side pause/redirect)
// Signals:
//   mem_req / mem_addr      fetch request and word-aligned address
//   mem_rdata / mem_valid   instruction word and its response strobe
//   inst_valid / inst_out / pc_out   FIFO head towards IF/ID
//   pause                   consumer stall
//   redirect / redirect_pc  flush and restart fetch at a new address
//   level                   FIFO occupancy
// ----------------------------------------------------------------------------
interface if_prefetch_queue_if #(
    parameter int DEPTH = 4
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic          mem_req;
    logic [31:0]   mem_addr;
    logic [31:0]   mem_rdata;
    logic          mem_valid;
    logic          inst_valid;
    logic [31:0]   inst_out;
    logic [31:0]   pc_out;
    logic          pause;
    logic          redirect;
    logic [31:0]   redirect_pc;
    logic [LW-1:0] level;

    modport master (
        output mem_req, mem_addr, inst_valid, inst_out, pc_out, level,
        input  mem_rdata, mem_valid, pause, redirect, redirect_pc
    );

    modport slave (
        input  mem_req, mem_addr, inst_valid, inst_out, pc_out, level,
        output mem_rdata, mem_valid, pause, redirect, redirect_pc
    );
endinterface

// File: rtl/if_prefetch_queue.sv
// ----------------------------------------------------------------------------
// if_prefetch_queue
// Instruction prefetch unit: issues one outstanding fetch at a time to the
// instruction memory and buffers returned words, tagged with their address,
// in a DEPTH-entry FIFO feeding the IF/ID register.
// Ports:
//   clk  - clock, all state updates on the rising edge
//   rst  - synchronous active-high reset
//   bus  - if_prefetch_queue_if.master (memory request/response, FIFO head,
//          pause, redirect, occupancy)
// A redirect flushes the FIFO and restarts fetch; a request already in flight
// when the redirect arrives is completed and its data thrown away (DROP).
// ----------------------------------------------------------------------------
module if_prefetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic                clk,
    input  logic                rst,
    if_prefetch_queue_if.master bus
);
    localparam int             PW       = $clog2(DEPTH);
    localparam int             LW       = PW + 1;
    localparam logic [LW-1:0]  FULL_LVL = LW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   req_addr_q;
    logic [LW-1:0] level_q, level_d;
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [31:0]   inst_mem [DEPTH];
    logic [31:0]   pc_mem   [DEPTH];
    logic          push, pop, load_req;

    // Low address bits of the redirect target are forced to zero.
    logic          unused_redirect_lsb;
    assign unused_redirect_lsb = ^bus.redirect_pc[1:0];

    always_comb begin
        push     = (state_q == WAIT) && bus.mem_valid && !bus.redirect;
        pop      = (level_q != '0) && !bus.pause && !bus.redirect;
        level_d  = level_q;
        if (bus.redirect)
            level_d = '0;
        else if (push && !pop)
            level_d = level_q + LW'(1);
        else if (!push && pop)
            level_d = level_q - LW'(1);

        fetch_pc_d = fetch_pc_q;
        if (bus.redirect)
            fetch_pc_d = {bus.redirect_pc[31:2], 2'b00};
        else if (push)
            fetch_pc_d = fetch_pc_q + 32'd4;

        state_d  = state_q;
        load_req = 1'b0;
        case (state_q)
            IDLE: begin
                if (!bus.redirect && (level_q < FULL_LVL)) begin
                    state_d  = WAIT;
                    load_req = 1'b1;
                end
            end
            WAIT: begin
                if (bus.redirect) begin
                    // In-flight word is either discarded now or later in DROP.
                    state_d = bus.mem_valid ? IDLE : DROP;
                end else if (bus.mem_valid) begin
                    // Back-to-back fetch only if the push leaves room.
                    if (level_d < FULL_LVL) begin
                        state_d  = WAIT;
                        load_req = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DROP: begin
                if (bus.mem_valid)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            req_addr_q <= RESET_PC;
            level_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                inst_mem[i] <= '0;
                pc_mem[i]   <= '0;
            end
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            level_q    <= level_d;
            if (load_req)
                req_addr_q <= fetch_pc_d;
            if (bus.redirect) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push) begin
                    inst_mem[wr_ptr_q] <= bus.mem_rdata;
                    pc_mem[wr_ptr_q]   <= req_addr_q;
                    wr_ptr_q           <= wr_ptr_q + PW'(1);
                end
                if (pop)
                    rd_ptr_q <= rd_ptr_q + PW'(1);
            end
        end
    end

    assign bus.mem_req    = (state_q == WAIT) || (state_q == DROP);
    assign bus.mem_addr   = req_addr_q;
    assign bus.inst_valid = (level_q != '0);
    assign bus.inst_out   = inst_mem[rd_ptr_q];
    assign bus.pc_out     = pc_mem[rd_ptr_q];
    assign bus.level      = level_q;
endmodule

// File: tb/tb_if_prefetch_queue.sv
// ----------------------------------------------------------------------------
// tb_if_prefetch_queue
// Scoreboard bench for if_prefetch_queue. Each phase pushes the fetch
// addresses it expects to see popped; a monitor compares every pop against
// the queue head. Direct checks cover reset, full/empty, redirect and DROP.
// The memory model answers with a word derived from the address after a
// programmable latency (0 = same-cycle response).
// ----------------------------------------------------------------------------
module tb_if_prefetch_queue;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    if_prefetch_queue_if #(.DEPTH(4)) bus();

    if_prefetch_queue #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          errors = 0;
    int          checks = 0;
    int          lat    = 0;
    int          cnt;
    logic [31:0] exp_q[$];
    logic        track  = 1'b0;
    int          max_lvl = 0;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return {a[15:0] ^ 16'hBEEF, a[15:0]};
    endfunction

    // Memory model
    always @(posedge clk) begin
        if (rst)
            cnt <= 0;
        else if (bus.mem_req && !bus.mem_valid)
            cnt <= cnt + 1;
        else
            cnt <= 0;
    end
    assign bus.mem_rdata = memfn(bus.mem_addr);
    assign bus.mem_valid = bus.mem_req && ((lat == 0) || (cnt == lat - 1));

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endfunction

    // Monitor: every accepted pop is compared with the scoreboard head.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (track && int'(bus.level) > max_lvl)
                max_lvl = int'(bus.level);
            if (!rst && bus.inst_valid && !bus.pause && !bus.redirect) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pop: got pc %h required no pop", bus.pc_out);
                end else begin
                    e = exp_q.pop_front();
                    chk("pop_pc", bus.pc_out, e);
                    chk("pop_inst", bus.inst_out, memfn(e));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int limit, output int cyc);
        cyc = 0;
        while (exp_q.size() != 0 && cyc < limit) begin
            @(posedge clk);
            cyc++;
        end
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left after %0d cycles, required 0", exp_q.size(), cyc);
            exp_q.delete();
        end
    endtask

    task automatic wait_for_cond(input string name, input int which, input int limit);
        int n = 0;
        bit hit = 1'b0;
        while (!hit && n < limit) begin
            case (which)
                0: hit = bus.mem_req && (bus.mem_addr == 32'h8);
                1: hit = (bus.level == 3'd3) && bus.mem_valid;
                default: hit = (bus.level == 3'd2) && bus.mem_req;
            endcase
            if (!hit) begin
                tick();
                n++;
            end
        end
        chk(name, {31'b0, hit}, 32'd1);
    endtask

    initial begin
        int cyc;
        rst = 1'b1;
        bus.pause = 1'b1;
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h0000_0040;
        tick();
        tick();
        // Reset overrides redirect
        chk("rst_mem_req", {31'b0, bus.mem_req}, 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'h0);
        chk("rst_inst_valid", {31'b0, bus.inst_valid}, 32'd0);
        chk("rst_inst_out", bus.inst_out, 32'h0);
        chk("rst_pc_out", bus.pc_out, 32'h0);
        chk("rst_level", 32'(bus.level), 32'd0);

        // Zero-wait streaming
        bus.redirect = 1'b0;
        rst = 1'b0;
        bus.pause = 1'b0;
        for (int i = 0; i < 8; i++) exp_q.push_back(32'(i * 4));
        track = 1'b1;
        drain(20, cyc);
        track = 1'b0;
        bus.pause = 1'b1;
        chk("stream_cycles_le_11", {31'b0, cyc <= 11}, 32'd1);
        chk("stream_level_le_2", {31'b0, max_lvl <= 2}, 32'd1);

        // Fill under pause, then release
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (8) tick();
        chk("full_level", 32'(bus.level), 32'd4);
        chk("full_mem_req", {31'b0, bus.mem_req}, 32'd0);
        chk("full_inst_valid", {31'b0, bus.inst_valid}, 32'd1);
        for (int i = 0; i < 5; i++) exp_q.push_back(32'(i * 4));
        bus.pause = 1'b0;
        drain(20, cyc);
        bus.pause = 1'b1;

        // Latency 3, redirect during the fetch at 0x8
        lat = 3;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        bus.pause = 1'b0;
        wait_for_cond("reach_fetch_8", 0, 40);
        tick();
        chk("w2_mem_addr", bus.mem_addr, 32'h8);
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h0000_0100;
        exp_q.delete();
        exp_q.push_back(32'h100);
        exp_q.push_back(32'h104);
        tick();
        bus.redirect = 1'b0;
        chk("drop_mem_req", {31'b0, bus.mem_req}, 32'd1);
        chk("drop_mem_addr", bus.mem_addr, 32'h8);
        chk("drop_inst_valid", {31'b0, bus.inst_valid}, 32'd0);
        tick();
        chk("after_drop_mem_req", {31'b0, bus.mem_req}, 32'd0);
        tick();
        chk("redir_mem_req", {31'b0, bus.mem_req}, 32'd1);
        chk("redir_mem_addr", bus.mem_addr, 32'h100);
        drain(40, cyc);
        bus.pause = 1'b1;

        // Redirect at level 3 coinciding with mem_valid, held for 4 cycles
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wait_for_cond("reach_level3_valid", 1, 40);
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h0000_0207;
        bus.pause = 1'b0;
        exp_q.delete();
        exp_q.push_back(32'h204);
        exp_q.push_back(32'h208);
        tick();
        chk("flush_level", 32'(bus.level), 32'd0);
        chk("flush_inst_valid", {31'b0, bus.inst_valid}, 32'd0);
        repeat (3) begin
            tick();
            chk("hold_redir_mem_req", {31'b0, bus.mem_req}, 32'd0);
            chk("hold_redir_level", 32'(bus.level), 32'd0);
        end
        bus.redirect = 1'b0;
        drain(40, cyc);
        bus.pause = 1'b1;

        // Address wrap
        lat = 0;
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'hFFFF_FFF8;
        exp_q.delete();
        exp_q.push_back(32'hFFFF_FFF8);
        exp_q.push_back(32'hFFFF_FFFC);
        exp_q.push_back(32'h0000_0000);
        exp_q.push_back(32'h0000_0004);
        tick();
        bus.redirect = 1'b0;
        bus.pause = 1'b0;
        drain(20, cyc);
        bus.pause = 1'b1;

        // Reset while a request is outstanding with two entries buffered
        lat = 3;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wait_for_cond("reach_level2_wait", 2, 40);
        rst = 1'b1;
        tick();
        chk("rstw_mem_req", {31'b0, bus.mem_req}, 32'd0);
        chk("rstw_mem_addr", bus.mem_addr, 32'h0);
        chk("rstw_inst_valid", {31'b0, bus.inst_valid}, 32'd0);
        chk("rstw_level", 32'(bus.level), 32'd0);
        chk("rstw_pc_out", bus.pc_out, 32'h0);
        rst = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end
endmodule
